// File: rtl/display_scheduler.sv
// display_scheduler: alternates the shared 7-segment display between the
// water-level view (selector=0) and the irrigation view (selector=1).
// Each view has its own dwell time, and a blanking gap separates the views.
// While force_water is high the display is pinned to the water view.
// All outputs are registered and decoded from the next state, so they
// change on the same edge as the state and there is no combinational path
// from the inputs to the outputs.
module display_scheduler #(
    parameter int WATER_DWELL  = 25_000_000,
    parameter int IRR_DWELL    = 25_000_000,
    parameter int BLANK_CYCLES = 1_000,
    parameter int CNT_W        = 32
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    input  logic force_water,
    output logic selector,
    output logic blank,
    output logic show_start
);

    typedef enum logic [1:0] {
        SHOW_WATER     = 2'd0,
        BLANK_TO_IRR   = 2'd1,
        SHOW_IRR       = 2'd2,
        BLANK_TO_WATER = 2'd3
    } state_t;

    // Terminal count for each state. When there is no blanking, the blank
    // states are never entered, so their terminal count is unused.
    localparam int              BLANK_LAST_I = (BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0;
    localparam logic [CNT_W-1:0] WATER_LAST  = CNT_W'(WATER_DWELL - 1);
    localparam logic [CNT_W-1:0] IRR_LAST    = CNT_W'(IRR_DWELL - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST  = CNT_W'(BLANK_LAST_I);
    localparam bit               HAS_BLANK   = (BLANK_CYCLES > 0);

    // The view after each show state depends on whether blanking is present.
    localparam state_t AFTER_WATER = HAS_BLANK ? BLANK_TO_IRR : SHOW_IRR;
    localparam state_t AFTER_IRR   = HAS_BLANK ? BLANK_TO_WATER : SHOW_WATER;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             selector_q, selector_d;
    logic             blank_q, blank_d;
    logic             show_start_q, show_start_d;
    logic [CNT_W-1:0] last_cnt;
    logic             at_last;

    // Next state, dwell counter and registered output decode.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        selector_d   = selector_q;
        blank_d      = blank_q;
        show_start_d = 1'b0;
        last_cnt     = WATER_LAST;

        case (state_q)
            SHOW_WATER: last_cnt = WATER_LAST;
            SHOW_IRR:   last_cnt = IRR_LAST;
            default:    last_cnt = BLANK_LAST;
        endcase
        at_last = (cnt_q == last_cnt);

        if (enable) begin
            cnt_d = cnt_q + 1'b1;
            case (state_q)
                SHOW_WATER: begin
                    // A held force keeps the count at zero so the water
                    // view never expires; releasing it gives a full dwell.
                    if (force_water) begin
                        cnt_d = '0;
                    end else if (at_last) begin
                        state_d = AFTER_WATER;
                        cnt_d   = '0;
                    end
                end
                BLANK_TO_IRR: begin
                    if (force_water) begin
                        state_d = BLANK_TO_WATER;
                        cnt_d   = '0;
                    end else if (at_last) begin
                        state_d = SHOW_IRR;
                        cnt_d   = '0;
                    end
                end
                SHOW_IRR: begin
                    // Force wins over a coincident dwell expiry; both go to
                    // the same place, but the force path is listed first.
                    if (force_water || at_last) begin
                        state_d = AFTER_IRR;
                        cnt_d   = '0;
                    end
                end
                BLANK_TO_WATER: begin
                    if (at_last) begin
                        state_d = SHOW_WATER;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = SHOW_WATER;
                    cnt_d   = '0;
                end
            endcase

            selector_d   = (state_d == BLANK_TO_IRR) || (state_d == SHOW_IRR);
            blank_d      = (state_d == BLANK_TO_IRR) || (state_d == BLANK_TO_WATER);
            show_start_d = (state_d != state_q) &&
                           ((state_d == SHOW_WATER) || (state_d == SHOW_IRR));
        end
    end

    // State, counter and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= SHOW_WATER;
            cnt_q        <= '0;
            selector_q   <= 1'b0;
            blank_q      <= 1'b0;
            show_start_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            selector_q   <= selector_d;
            blank_q      <= blank_d;
            show_start_q <= show_start_d;
        end
    end

    assign selector   = selector_q;
    assign blank      = blank_q;
    assign show_start = show_start_q;

endmodule

// File: tb/tb_display_scheduler.sv
// Testbench for display_scheduler. Directed scenarios are written as two
// strings per scenario: a control string (inputs applied during each cycle)
// and an expected-view string (outputs seen during that same cycle).
// View codes: W water, w water + show_start, B blank-to-irr, I irrigation,
//             i irrigation + show_start, b blank-to-water, - not checked.
// Control codes: R reset, . run, F run+force, o disabled, x disabled+force.
module tb_display_scheduler;

    logic clock = 1'b0;
    logic reset, enable, force_water;
    logic sel0, blk0, ss0;
    logic sel1, blk1, ss1;

    always #5 clock = ~clock;

    // Main DUT with blanking, second DUT without blanking.
    display_scheduler #(
        .WATER_DWELL(4), .IRR_DWELL(3), .BLANK_CYCLES(2), .CNT_W(8)
    ) dut_blank (
        .clock(clock), .reset(reset), .enable(enable), .force_water(force_water),
        .selector(sel0), .blank(blk0), .show_start(ss0)
    );

    display_scheduler #(
        .WATER_DWELL(4), .IRR_DWELL(3), .BLANK_CYCLES(0), .CNT_W(8)
    ) dut_noblank (
        .clock(clock), .reset(reset), .enable(enable), .force_water(force_water),
        .selector(sel1), .blank(blk1), .show_start(ss1)
    );

    typedef struct {
        int         dut;
        int         scn;
        int         cyc;
        logic [2:0] exp;
    } item_t;

    item_t q[$];
    int    checks = 0;
    int    errors = 0;

    // {selector, blank, show_start} for each view code.
    function automatic logic [2:0] decode(input byte c);
        case (c)
            "W":     return 3'b000;
            "w":     return 3'b001;
            "B":     return 3'b110;
            "I":     return 3'b100;
            "i":     return 3'b101;
            "b":     return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    task automatic run_scn(input int scn, input int dut, input string ctl, input string exp);
        item_t it;
        for (int i = 0; i < ctl.len(); i++) begin
            reset       = (ctl[i] == "R");
            enable      = (ctl[i] == "R") || (ctl[i] == ".") || (ctl[i] == "F");
            force_water = (ctl[i] == "F") || (ctl[i] == "x");
            if (exp[i] != "-") begin
                it.dut = dut;
                it.scn = scn;
                it.cyc = i - 1;
                it.exp = decode(exp[i]);
                q.push_back(it);
            end
            @(posedge clock);
            #1;
        end
    endtask

    // Monitor: compares the DUT outputs mid-cycle against queued expectations.
    initial begin
        item_t      it;
        logic [2:0] act;
        forever begin
            @(negedge clock);
            if (q.size() > 0) begin
                it  = q.pop_front();
                act = (it.dut == 0) ? {sel0, blk0, ss0} : {sel1, blk1, ss1};
                checks++;
                if (act !== it.exp) begin
                    errors++;
                    $display("FAIL scn%0d cycle %0d dut%0d: sel/blank/start got %b required %b",
                             it.scn, it.cyc, it.dut, act, it.exp);
                end
            end
        end
    end

    initial begin
        int guard;
        reset       = 1'b1;
        enable      = 1'b0;
        force_water = 1'b0;
        repeat (3) @(posedge clock);
        #1;

        // 1: free run, period 11.
        run_scn(1, 0, "R.......................",
                      "-WWWWBBiIIbbwWWWBBiIIbbw");
        // 2: force during irrigation, held, then released.
        run_scn(2, 0, "R.......FFFFFFFFFFFFF.......",
                      "-WWWWBBiIbbwWWWWWWWWWWWWWBBi");
        // 3: enable freeze, then disable while show_start is high with force ignored.
        run_scn(3, 0, "R..ooooo....xx......",
                      "-WWWWWWWWWBBiIIIIbbw");
        // 4: reset in the middle of the blanking gap.
        run_scn(4, 0, "R.....R.......",
                      "-WWWWBBWWWWBBi");
        // 5: force coincides with water dwell expiry.
        run_scn(5, 0, "R...F.......",
                      "-WWWWWWWWBBi");
        // 6: force during blank-to-irrigation.
        run_scn(6, 0, "R....F.......",
                      "-WWWWBbbwWWWB");
        // 7: no blanking, free run.
        run_scn(7, 1, "R............",
                      "-WWWWiIIwWWWi");
        // 8: no blanking, force during irrigation goes straight to water.
        run_scn(8, 1, "R.....F......",
                      "-WWWWiIwWWWiI");

        guard = 0;
        while (q.size() > 0 && guard < 10) begin
            @(posedge clock);
            guard++;
        end
        if (q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
